// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter-to-RAM port: channel IDs, the read-tag format
// and the legal RAM latency range.
package arb_pkg;

    localparam logic [1:0] CH_A = 2'd0;
    localparam logic [1:0] CH_B = 2'd1;
    localparam logic [1:0] CH_C = 2'd2;

    localparam int TAG_W = 3;

    typedef struct packed {
        logic       vld;
        logic [1:0] chan;
    } tag_t;

    localparam int RAM_LAT_MIN = 1;
    localparam int RAM_LAT_MAX = 4;

    function automatic bit ram_lat_ok(input int lat);
        return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
    endfunction

endpackage

// File: rtl/arb_tag_pipe.sv
// Shift register of read tags, DEPTH entries, one shift per cycle; no stall.
// A synchronous clear drops every tag that is in flight.
module arb_tag_pipe
    import arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [TAG_W-1:0] tag_in,
    output logic [TAG_W-1:0] tag_out
);

    logic [TAG_W-1:0] stage_q [DEPTH];
    logic [TAG_W-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/arb_ram_port.sv
// Muxes the one-hot arbiter grant onto a single-port RAM one cycle after the ack and returns
// read data to the requesting channel RAM_LAT+2 cycles after the ack; no backpressure.
module arb_ram_port
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int RAM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ackA,
    input  logic                  ackB,
    input  logic                  ackC,
    input  logic [ADDR_WIDTH-1:0] addressA,
    input  logic [ADDR_WIDTH-1:0] addressB,
    input  logic [ADDR_WIDTH-1:0] addressC,
    input  logic [DATA_WIDTH-1:0] wrdataA,
    input  logic [DATA_WIDTH-1:0] wrdataB,
    input  logic [DATA_WIDTH-1:0] wrdataC,
    input  logic                  rdWrnA,
    input  logic                  rdWrnB,
    input  logic                  rdWrnC,
    output logic [DATA_WIDTH-1:0] rddataA,
    output logic [DATA_WIDTH-1:0] rddataB,
    output logic [DATA_WIDTH-1:0] rddataC,
    output logic                  rdvalidA,
    output logic                  rdvalidB,
    output logic                  rdvalidC,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  grant_err
);

    if (!ram_lat_ok(RAM_LAT)) begin : g_bad_ram_lat
        $error("arb_ram_port: RAM_LAT %0d outside supported range 1..4", RAM_LAT);
    end

    logic [2:0]            ack;
    logic                  one_hot;
    logic                  multi_hot;
    logic [1:0]            sel_chan;
    logic                  sel_rd;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  grant_err_q, grant_err_d;
    logic [2:0]            rdvalid_q, rdvalid_d;
    logic [DATA_WIDTH-1:0] rddata_a_q, rddata_a_d;
    logic [DATA_WIDTH-1:0] rddata_b_q, rddata_b_d;
    logic [DATA_WIDTH-1:0] rddata_c_q, rddata_c_d;

    tag_t             tag_in;
    tag_t             tag_out;
    logic [TAG_W-1:0] tag_out_raw;

    assign ack = {ackC, ackB, ackA};

    always_comb begin
        one_hot   = (ack == 3'b001) || (ack == 3'b010) || (ack == 3'b100);
        multi_hot = (ack != 3'b000) && !one_hot;

        sel_chan  = CH_A;
        sel_rd    = rdWrnA;
        sel_addr  = addressA;
        sel_wdata = wrdataA;
        case (ack)
            3'b010: begin
                sel_chan  = CH_B;
                sel_rd    = rdWrnB;
                sel_addr  = addressB;
                sel_wdata = wrdataB;
            end
            3'b100: begin
                sel_chan  = CH_C;
                sel_rd    = rdWrnC;
                sel_addr  = addressC;
                sel_wdata = wrdataC;
            end
            default: ;
        endcase

        // Address and write data only move on a legal grant so the RAM pins stay quiet when idle.
        ram_en_d    = one_hot;
        ram_we_d    = one_hot & ~sel_rd;
        ram_addr_d  = one_hot ? sel_addr  : ram_addr_q;
        ram_wdata_d = one_hot ? sel_wdata : ram_wdata_q;
        grant_err_d = grant_err_q | multi_hot;

        // The tag is loaded alongside the command so it sits in the pipe during the ram_en cycle.
        tag_in.vld  = one_hot & sel_rd;
        tag_in.chan = sel_chan;

        rdvalid_d  = 3'b000;
        rddata_a_d = rddata_a_q;
        rddata_b_d = rddata_b_q;
        rddata_c_d = rddata_c_q;
        if (tag_out.vld) begin
            case (tag_out.chan)
                CH_A: begin
                    rdvalid_d[0] = 1'b1;
                    rddata_a_d   = ram_rdata;
                end
                CH_B: begin
                    rdvalid_d[1] = 1'b1;
                    rddata_b_d   = ram_rdata;
                end
                CH_C: begin
                    rdvalid_d[2] = 1'b1;
                    rddata_c_d   = ram_rdata;
                end
                default: ;
            endcase
        end
    end

    arb_tag_pipe #(
        .DEPTH (RAM_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .clr     (reset),
        .tag_in  (tag_in),
        .tag_out (tag_out_raw)
    );

    assign tag_out = tag_t'(tag_out_raw);

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            grant_err_q <= 1'b0;
            rdvalid_q   <= 3'b000;
            rddata_a_q  <= '0;
            rddata_b_q  <= '0;
            rddata_c_q  <= '0;
        end else begin
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            grant_err_q <= grant_err_d;
            rdvalid_q   <= rdvalid_d;
            rddata_a_q  <= rddata_a_d;
            rddata_b_q  <= rddata_b_d;
            rddata_c_q  <= rddata_c_d;
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign grant_err = grant_err_q;
    assign rdvalidA  = rdvalid_q[0];
    assign rdvalidB  = rdvalid_q[1];
    assign rdvalidC  = rdvalid_q[2];
    assign rddataA   = rddata_a_q;
    assign rddataB   = rddata_b_q;
    assign rddataC   = rddata_c_q;

endmodule

// File: tb/tb_arb_ram_port.sv
// Three copies of the port (RAM_LAT 1, 2, 3) share one stimulus stream, each with its
// own read-first RAM model; directed vectors check cycle-exact behaviour.
module tb_arb_ram_port;

    logic clk = 1'b0;
    logic reset;
    logic ackA, ackB, ackC;
    logic [11:0] addressA, addressB, addressC;
    logic [7:0]  wrdataA, wrdataB, wrdataC;
    logic        rdWrnA, rdWrnB, rdWrnC;

    logic [2:0]       rdv_a, rdv_b, rdv_c, ram_en, ram_we, gerr;
    logic [2:0][7:0]  rdd_a, rdd_b, rdd_c, ram_wdata, ram_rdata;
    logic [2:0][11:0] ram_addr;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0]  t6_ack  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic        t6_rd   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [11:0] t6_addr [6] = '{12'hFFF, 12'h000, 12'h800, 12'hFFF, 12'h000, 12'h800};
    logic [7:0]  t6_data [6] = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = g + 1;
        logic [7:0] mem     [4096];
        logic [7:0] rd_pipe [LAT];

        always_ff @(posedge clk) begin
            if (ram_en[g]) begin
                if (ram_we[g]) mem[ram_addr[g]] <= ram_wdata[g];
                rd_pipe[0] <= mem[ram_addr[g]];
            end
            for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
        assign ram_rdata[g] = rd_pipe[LAT-1];

        arb_ram_port #(
            .ADDR_WIDTH (12),
            .DATA_WIDTH (8),
            .RAM_LAT    (LAT)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .ackA      (ackA),
            .ackB      (ackB),
            .ackC      (ackC),
            .addressA  (addressA),
            .addressB  (addressB),
            .addressC  (addressC),
            .wrdataA   (wrdataA),
            .wrdataB   (wrdataB),
            .wrdataC   (wrdataC),
            .rdWrnA    (rdWrnA),
            .rdWrnB    (rdWrnB),
            .rdWrnC    (rdWrnC),
            .rddataA   (rdd_a[g]),
            .rddataB   (rdd_b[g]),
            .rddataC   (rdd_c[g]),
            .rdvalidA  (rdv_a[g]),
            .rdvalidB  (rdv_b[g]),
            .rdvalidC  (rdv_c[g]),
            .ram_en    (ram_en[g]),
            .ram_we    (ram_we[g]),
            .ram_addr  (ram_addr[g]),
            .ram_wdata (ram_wdata[g]),
            .ram_rdata (ram_rdata[g]),
            .grant_err (gerr[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Unselected channels carry inverted values so a wrong mux leg is visible.
    task automatic drive(input logic [2:0] ack, input logic rd, input logic [11:0] a,
                         input logic [7:0] d);
        ackA = ack[0];
        ackB = ack[1];
        ackC = ack[2];
        addressA = ack[0] ? a : ~a;
        addressB = ack[1] ? a : ~a;
        addressC = ack[2] ? a : ~a;
        wrdataA  = ack[0] ? d : ~d;
        wrdataB  = ack[1] ? d : ~d;
        wrdataC  = ack[2] ? d : ~d;
        rdWrnA   = ack[0] ? rd : ~rd;
        rdWrnB   = ack[1] ? rd : ~rd;
        rdWrnC   = ack[2] ? rd : ~rd;
    endtask

    task automatic idle();
        drive(3'b000, 1'b1, 12'h000, 8'h00);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hits;
        int we_cnt, cnt_a, cnt_b, cnt_c, multi;

        reset = 1'b1;
        idle();
        repeat (3) tick();
        check("rst_ram_en",  32'(ram_en), 32'h0);
        check("rst_ram_we",  32'(ram_we), 32'h0);
        check("rst_addr",    32'(ram_addr[0]), 32'h0);
        check("rst_wdata",   32'(ram_wdata[0]), 32'h0);
        check("rst_rddata",  32'({rdd_a[0], rdd_b[0], rdd_c[0]}), 32'h0);
        check("rst_rdvalid", 32'({rdv_a, rdv_b, rdv_c}), 32'h0);
        check("rst_gerr",    32'(gerr), 32'h0);
        reset = 1'b0;

        // Write then read on channel A, RAM_LAT=1
        drive(3'b001, 1'b0, 12'h010, 8'h5A);
        tick();
        check("t1_wr_en_we", 32'({ram_en[0], ram_we[0]}), 32'h3);
        check("t1_wr_addr",  32'(ram_addr[0]), 32'h010);
        check("t1_wr_data",  32'(ram_wdata[0]), 32'h5A);
        drive(3'b001, 1'b1, 12'h010, 8'h00);
        tick();
        check("t1_rd_en_we", 32'({ram_en[0], ram_we[0]}), 32'h2);
        idle();
        tick();
        check("t1_early", 32'(rdv_a[0]), 32'h0);
        tick();
        check("t1_rdvalid", 32'({rdv_a[0], rdv_b[0], rdv_c[0]}), 32'h4);
        check("t1_rddata",  32'(rdd_a[0]), 32'h5A);
        tick();
        check("t1_strobe_end", 32'(rdv_a[0]), 32'h0);
        check("t1_hold",       32'(rdd_a[0]), 32'h5A);

        // Read followed by write to the same address returns the old data
        drive(3'b001, 1'b1, 12'h010, 8'h00);
        tick();
        drive(3'b001, 1'b0, 12'h010, 8'h77);
        tick();
        idle();
        tick();
        check("rw_old_vld",  32'(rdv_a[0]), 32'h1);
        check("rw_old_data", 32'(rdd_a[0]), 32'h5A);
        drive(3'b001, 1'b1, 12'h010, 8'h00);
        tick();
        idle();
        tick();
        tick();
        check("rw_new_data", 32'(rdd_a[0]), 32'h77);

        // Interleaved reads on B, C, A with RAM_LAT=3
        drive(3'b001, 1'b0, 12'h001, 8'h11);
        tick();
        drive(3'b001, 1'b0, 12'h002, 8'h22);
        tick();
        drive(3'b001, 1'b0, 12'h003, 8'h33);
        tick();
        idle();
        tick();
        drive(3'b010, 1'b1, 12'h001, 8'h00);
        tick();
        drive(3'b100, 1'b1, 12'h002, 8'h00);
        tick();
        drive(3'b001, 1'b1, 12'h003, 8'h00);
        tick();
        idle();
        tick();
        check("t2_quiet", 32'({rdv_a[2], rdv_b[2], rdv_c[2]}), 32'h0);
        tick();
        check("t2_b_vld", 32'({rdv_a[2], rdv_b[2], rdv_c[2]}), 32'h2);
        check("t2_b_dat", 32'(rdd_b[2]), 32'h11);
        tick();
        check("t2_c_vld", 32'({rdv_a[2], rdv_b[2], rdv_c[2]}), 32'h1);
        check("t2_c_dat", 32'(rdd_c[2]), 32'h22);
        tick();
        check("t2_a_vld", 32'({rdv_a[2], rdv_b[2], rdv_c[2]}), 32'h4);
        check("t2_a_dat", 32'(rdd_a[2]), 32'h33);
        idle();
        tick();

        // Multi-hot grant
        drive(3'b011, 1'b0, 12'h020, 8'h99);
        tick();
        check("t3_no_en", 32'(ram_en), 32'h0);
        check("t3_err",   32'(gerr), 32'h7);
        drive(3'b010, 1'b0, 12'h020, 8'h44);
        tick();
        check("t3_legal_en", 32'(ram_en), 32'h7);
        idle();
        repeat (3) tick();
        check("t3_sticky", 32'(gerr), 32'h7);

        // Reset mid-flight, with a grant presented during reset
        drive(3'b100, 1'b1, 12'h002, 8'h00);
        tick();
        reset = 1'b1;
        drive(3'b001, 1'b1, 12'h003, 8'h00);
        tick();
        reset = 1'b0;
        idle();
        check("t4_en_after_rst", 32'(ram_en), 32'h0);
        check("t4_gerr_clr",     32'(gerr), 32'h0);
        hits = 0;
        repeat (8) begin
            tick();
            hits += int'((rdv_a | rdv_b | rdv_c) != 3'b000);
        end
        check("t4_no_rdvalid", 32'(hits), 32'h0);
        check("t4_rddata_c",   32'({rdd_c[0], rdd_c[1], rdd_c[2]}), 32'h0);
        check("t4_rddata_a",   32'({rdd_a[0], rdd_a[1], rdd_a[2]}), 32'h0);

        // Back-to-back writes then reads on A, B, C
        we_cnt = 0;
        cnt_a  = 0;
        cnt_b  = 0;
        cnt_c  = 0;
        multi  = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 6) drive(t6_ack[c], t6_rd[c], t6_addr[c], t6_data[c]);
            else idle();
            tick();
            we_cnt += int'(ram_en[0] & ram_we[0]);
            cnt_a  += int'(rdv_a[0]);
            cnt_b  += int'(rdv_b[0]);
            cnt_c  += int'(rdv_c[0]);
            if ($countones({rdv_a[0], rdv_b[0], rdv_c[0]}) > 1) multi++;
        end
        check("t6_we_pulses", 32'(we_cnt), 32'd3);
        check("t6_cnt_a",     32'(cnt_a), 32'd1);
        check("t6_cnt_b",     32'(cnt_b), 32'd1);
        check("t6_cnt_c",     32'(cnt_c), 32'd1);
        check("t6_one_hot",   32'(multi), 32'd0);
        check("t6_data_l1",   32'({rdd_a[0], rdd_b[0], rdd_c[0]}), 32'hA1B2C3);
        check("t6_data_l3",   32'({rdd_a[2], rdd_b[2], rdd_c[2]}), 32'hA1B2C3);

        // Idle: no access, address held at last access, no strobes
        hits = 0;
        repeat (20) begin
            tick();
            if (ram_en != 3'b000 || ram_addr[0] != 12'h800 || (rdv_a | rdv_b | rdv_c) != 3'b000)
                hits++;
        end
        check("t5_idle_quiet", 32'(hits), 32'h0);
        check("t5_addr_held",  32'(ram_addr[0]), 32'h800);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/arb_ram_port.md
Name: arb_ram_port

Overview:
- Stage directly downstream of the 3-way round-robin arbiter.
- Takes the arbiter's one-hot grant (ackA/ackB/ackC) and the three channel request buses, and muxes the granted channel onto a single-port synchronous RAM.
- Tracks in-flight reads with a channel-tag pipeline and returns read data to the originating channel with a one-cycle valid strobe.

Parameters:
- ADDR_WIDTH, 12, RAM/channel address width.
- DATA_WIDTH, 8, RAM/channel data width.
- RAM_LAT, 1, RAM read latency in cycles from the ram_en edge to valid ram_rdata; legal range 1..4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ackA / ackB / ackC  in  1 each  grant from arbiter, expected one-hot or zero
- addressA / addressB / addressC  in  ADDR_WIDTH  channel address
- wrdataA / wrdataB / wrdataC  in  DATA_WIDTH  channel write data
- rdWrnA / rdWrnB / rdWrnC  in  1  1 = read, 0 = write
- rddataA / rddataB / rddataC  out  DATA_WIDTH  returned read data, held until the next read for that channel
- rdvalidA / rdvalidB / rdvalidC  out  1  one-cycle strobe, rddataX updated this cycle
- ram_en  out  1  RAM access enable
- ram_we  out  1  RAM write enable, only meaningful with ram_en
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_wdata  out  DATA_WIDTH  RAM write data
- ram_rdata  in  DATA_WIDTH  RAM read data
- grant_err  out  1  sticky: multi-hot grant seen

Behaviour:
- Reset: every output goes to 0 (ram_*, rddataX, rdvalidX, grant_err); the tag pipeline is cleared.

Command stage (registered):
- Grant sampled in cycle T with exactly one ackX high gives, in cycle T+1:
  - ram_en = 1
  - ram_we = ~rdWrnX
  - ram_addr = addressX
  - ram_wdata = wrdataX
- Zero grants: ram_en = ram_we = 0 in T+1. ram_addr and ram_wdata hold their previous values (no toggling when idle).
- Multi-hot grant: no access (ram_en = 0), grant_err set and held until reset.
- Back-to-back grants are accepted every cycle; there is no backpressure and no ready signal.

Tag pipeline:
- Depth RAM_LAT+1 entries of {valid, chan[1:0]}, shifted every cycle.
- Entry pushed in T+1 with valid = ram_en & ~ram_we, chan = granted channel.
- ram_rdata is valid during cycle T+1+RAM_LAT.
- When the tag at that stage is valid, ram_rdata is captured into rddata[chan] and rdvalid[chan] = 1 during cycle T+2+RAM_LAT.
- Read latency from ack to rdvalid is therefore RAM_LAT+2 cycles.
- Writes produce no response.
- At most one rdvalidX is high per cycle; all others are 0.
- rddataX for non-addressed channels is unchanged.

Boundary conditions:
- Read immediately followed by a write to the same address (consecutive cycles): the read returns the old data (RAM read-first semantics are assumed of the macro and are not corrected here).
- Reads from different channels on consecutive cycles: responses return in grant order, one per cycle.
- Reset asserted mid-flight: all in-flight reads are dropped, with no rdvalid after reset deasserts.
- Grant while reset is high: ignored.

Decomposition:
- Shared package arb_pkg holds:
  - Channel ID constants: CH_A = 2'd0, CH_B = 2'd1, CH_C = 2'd2.
  - Tag type width (valid + 2-bit chan).
  - RAM_LAT legal-range check.
- Sub-module arb_tag_pipe: parameterised-depth shift register of {valid, chan} with synchronous clear. It is instantiated once.

Test Plan:
1. Write then read, channel A: ackA with rdWrnA=0, addressA=12'h010, wrdataA=8'h5A; next cycle, read the same address.
   -> ram_we pulse at T+1; rdvalidA high at T_read+3 (RAM_LAT=1) with rddataA=8'h5A.
2. Interleaved reads, RAM_LAT=3: reads on consecutive cycles B@12'h001, C@12'h002, A@12'h003, with RAM preloaded 8'h11/22/33.
   -> rdvalidB, rdvalidC, rdvalidA on consecutive cycles starting at T+5, with data 8'h11, 8'h22, 8'h33.
3. Multi-hot grant: ackA=ackB=1 for one cycle.
   -> ram_en stays 0; grant_err=1 and stays 1 through subsequent legal traffic until reset.
4. Reset mid-flight: issue a read on C, assert reset for 1 cycle at T+1 (RAM_LAT=2).
   -> no rdvalidC ever; rddataC=0.
5. Idle: 20 cycles with no ack.
   -> ram_en=0 and ram_addr stable throughout; all rdvalidX stay 0.
6. Back-to-back writes A, B, C to 12'hFFF, 12'h000, 12'h800, then read all three.
   -> exactly three ram_we pulses; each read returns the matching wrdata to its own channel only.
